// File: rtl/spi_up_bridge_os.sv
// spi_up_bridge_os: SPI slave to microprocessor register bus bridge.
// Every SPI pin is oversampled in the up_clk domain. The block has no
// SPI-clock-domain logic.
// Frame: CMD (0x01 write, 0x02 read), ADDR_W/8 address bytes, then data.
// Optional macro SPI_UP_BRIDGE_BURST_EN enables address auto-increment
// for further words in the same frame.
// Valid/ready note: the up bus has no back-pressure. up_wr and up_rd are
// single-cycle strobes that qualify up_addr and up_wr_data. up_rd_data is
// sampled exactly RD_LAT cycles after up_rd.
module spi_up_bridge_os #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0,
  parameter int RD_LAT = 2
) (
  input  logic              up_clk,
  input  logic              up_rst,
  input  logic              spi_cs,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] up_addr,
  output logic              up_wr,
  output logic              up_rd,
  output logic [DATA_W-1:0] up_wr_data,
  input  logic [DATA_W-1:0] up_rd_data,
  output logic              cmd_err
);

`ifdef SPI_UP_BRIDGE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int DATA_BYTES = DATA_W / 8;
  localparam int BC_W       = 4;
  localparam int TXC_W      = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WDATA, RTURN, RDATA, IGNORE
  } state_t;

  state_t state;

  // Synchronisers and edge-detect history
  logic cs_meta, cs_sync, cs_hist;
  logic clk_meta, clk_sync, clk_hist;
  logic mosi_meta, mosi_sync;

  // The synchronisers only track the pins and are deliberately left out of
  // reset. A reset while CS is already low then produces no false CS fall,
  // so the frame in progress stays abandoned.
  always_ff @(posedge up_clk) begin
    cs_meta   <= spi_cs;
    cs_sync   <= cs_meta;
    cs_hist   <= cs_sync;
    clk_meta  <= spi_clk;
    clk_sync  <= clk_meta;
    clk_hist  <= clk_sync;
    mosi_meta <= spi_mosi;
    mosi_sync <= mosi_meta;
  end

  logic clk_rise, clk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, cs_fall, cs_rise;

  assign clk_rise    = clk_sync & ~clk_hist;
  assign clk_fall    = ~clk_sync & clk_hist;
  assign lead_edge   = (CPOL == 0) ? clk_rise : clk_fall;
  assign trail_edge  = (CPOL == 0) ? clk_fall : clk_rise;
  assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
  assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
  assign cs_fall     = cs_hist & ~cs_sync;
  assign cs_rise     = ~cs_hist & cs_sync;

  // Byte assembly: MSB-first shift. byte_done fires the cycle after the 8th sample.
  logic [7:0] rx_sr;
  logic [2:0] bit_cnt;
  logic       byte_done;

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      rx_sr     <= '0;
      bit_cnt   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (state == IDLE || cs_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge && !cs_sync) begin
        rx_sr   <= {rx_sr[6:0], mosi_sync};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_done <= 1'b1;
      end
    end
  end

  // Read-latency pipeline. It runs independently of the FSM, so an issued
  // read still captures its data after the frame is aborted.
  logic [RD_LAT-1:0] rd_pipe;
  logic [DATA_W-1:0] tx_word;

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      rd_pipe <= '0;
      tx_word <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | RD_LAT'(up_rd);
      if (rd_pipe[RD_LAT-1]) tx_word <= up_rd_data;
    end
  end

  // Frame FSM with registered bus strobes, address/data accumulation and TX shifting
  logic [BC_W-1:0]   byte_cnt;
  logic              is_read;
  logic [ADDR_W-1:0] addr_acc, addr_next;
  logic [DATA_W-1:0] data_acc, data_next;
  logic [DATA_W-1:0] tx_sr;
  logic              tx_armed;
  logic [TXC_W-1:0]  tx_cnt;
  logic              miso_q;

  assign addr_next = (addr_acc << 8) | ADDR_W'(rx_sr);
  assign data_next = (data_acc << 8) | DATA_W'(rx_sr);

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state      <= IDLE;
      up_addr    <= '0;
      up_wr      <= 1'b0;
      up_rd      <= 1'b0;
      up_wr_data <= '0;
      cmd_err    <= 1'b0;
      byte_cnt   <= '0;
      is_read    <= 1'b0;
      addr_acc   <= '0;
      data_acc   <= '0;
      tx_sr      <= '0;
      tx_armed   <= 1'b0;
      tx_cnt     <= '0;
      miso_q     <= 1'b0;
    end else begin
      up_wr   <= 1'b0;
      up_rd   <= 1'b0;
      cmd_err <= 1'b0;
      // A burst write steps the address only after the strobe has been seen.
      if (BURST && up_wr && !cs_sync) up_addr <= up_addr + ADDR_W'(DATA_BYTES);
      if (cs_rise) begin
        state    <= IDLE;
        byte_cnt <= '0;
        tx_cnt   <= '0;
        tx_armed <= 1'b0;
        miso_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state    <= CMD;
              byte_cnt <= '0;
            end
          end
          CMD: begin
            if (byte_done) begin
              byte_cnt <= '0;
              case (rx_sr)
                8'h01: begin is_read <= 1'b0; state <= ADDR; end
                8'h02: begin is_read <= 1'b1; state <= ADDR; end
                default: begin cmd_err <= 1'b1; state <= IGNORE; end
              endcase
            end
          end
          ADDR: begin
            if (byte_done) begin
              addr_acc <= addr_next;
              if (byte_cnt == BC_W'(ADDR_BYTES - 1)) begin
                byte_cnt <= '0;
                up_addr  <= addr_next;
                if (is_read) begin
                  up_rd <= 1'b1;
                  state <= RTURN;
                end else begin
                  state <= WDATA;
                end
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          WDATA: begin
            if (byte_done) begin
              data_acc <= data_next;
              if (byte_cnt == BC_W'(DATA_BYTES - 1)) begin
                byte_cnt   <= '0;
                up_wr_data <= data_next;
                up_wr      <= 1'b1;
                if (!BURST) state <= IGNORE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          RTURN: begin
            // Dummy byte: MISO stays low. The word is loaded at its end.
            if (byte_done) begin
              state <= RDATA;
              if (CPHA == 0) begin
                miso_q   <= tx_word[DATA_W-1];
                tx_sr    <= tx_word << 1;
                tx_armed <= 1'b0;
                tx_cnt   <= TXC_W'(1);
              end else begin
                tx_sr    <= tx_word;
                tx_armed <= 1'b1;
                tx_cnt   <= '0;
              end
            end
          end
          RDATA: begin
            // Shift only after a sample since the last drive. This skips
            // the trailing edge that ends the previous byte when CPHA=0.
            if (shift_edge && tx_armed) begin
              miso_q   <= tx_sr[DATA_W-1];
              tx_sr    <= tx_sr << 1;
              tx_armed <= 1'b0;
              tx_cnt   <= tx_cnt + 1'b1;
              if (BURST && tx_cnt == TXC_W'(DATA_W - 1)) begin
                up_rd   <= 1'b1;
                up_addr <= up_addr + ADDR_W'(DATA_BYTES);
              end
            end else if (sample_edge) begin
              tx_armed <= 1'b1;
            end
            if (byte_done) begin
              if (byte_cnt == BC_W'(DATA_BYTES - 1)) begin
                byte_cnt <= '0;
                if (!BURST) begin
                  state  <= IGNORE;
                  miso_q <= 1'b0;
                end else if (CPHA == 0) begin
                  miso_q   <= tx_word[DATA_W-1];
                  tx_sr    <= tx_word << 1;
                  tx_armed <= 1'b0;
                  tx_cnt   <= TXC_W'(1);
                end else begin
                  tx_sr    <= tx_word;
                  tx_armed <= 1'b1;
                  tx_cnt   <= '0;
                end
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          IGNORE: begin
            miso_q <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // MISO is driven only inside the read data phase while CS is asserted.
  assign spi_miso = miso_q & (state == RDATA) & ~spi_cs;

endmodule

// File: tb/tb_spi_up_bridge_os.sv
// Bench for spi_up_bridge_os: a mode-0 instance and a CPOL=1/CPHA=1 instance.
// Expected bus events and MISO bytes are queued when stimulus is issued.
// Monitors pop and compare them when the DUT strobes or when a byte is received.
module tb_spi_up_bridge_os;
  localparam int HALF   = 40;
  localparam int RD_LAT = 2;
  localparam logic [2:0] K_WR = 3'b001;
  localparam logic [2:0] K_RD = 3'b010;
  localparam logic [2:0] K_ER = 3'b100;

  int checks = 0;
  int errors = 0;

  logic up_clk = 1'b0;
  logic up_rst = 1'b1;

  logic cs0 = 1'b1, sclk0 = 1'b0, mosi0 = 1'b0, miso0;
  logic [31:0] addr0, wdata0, rdata0;
  logic wr0, rd0, err0;
  logic cs3 = 1'b1, sclk3 = 1'b1, mosi3 = 1'b0, miso3;
  logic [31:0] addr3, wdata3, rdata3;
  logic wr3, rd3, err3;

  logic [31:0] rval0 = 32'h0, rval3 = 32'h0;
  logic [3:0]  age0 = 4'd0, age3 = 4'd0;

  logic [66:0] bus_exp0[$];
  logic [66:0] bus_exp3[$];
  logic [7:0]  miso_exp0[$];
  logic [7:0]  miso_got0[$];
  logic [7:0]  miso_exp3[$];
  logic [7:0]  miso_got3[$];

  // Clock
  always #5 up_clk = ~up_clk;

  spi_up_bridge_os dut0 (
    .up_clk(up_clk), .up_rst(up_rst), .spi_cs(cs0), .spi_clk(sclk0),
    .spi_mosi(mosi0), .spi_miso(miso0), .up_addr(addr0), .up_wr(wr0),
    .up_rd(rd0), .up_wr_data(wdata0), .up_rd_data(rdata0), .cmd_err(err0)
  );

  spi_up_bridge_os #(.CPOL(1), .CPHA(1)) dut3 (
    .up_clk(up_clk), .up_rst(up_rst), .spi_cs(cs3), .spi_clk(sclk3),
    .spi_mosi(mosi3), .spi_miso(miso3), .up_addr(addr3), .up_wr(wr3),
    .up_rd(rd3), .up_wr_data(wdata3), .up_rd_data(rdata3), .cmd_err(err3)
  );

  // Register-file model: read data is valid only exactly RD_LAT cycles after up_rd
  always @(posedge up_clk) begin
    if (rd0) age0 <= 4'd1; else if (age0 != 4'd0 && age0 != 4'd15) age0 <= age0 + 4'd1;
    if (rd3) age3 <= 4'd1; else if (age3 != 4'd0 && age3 != 4'd15) age3 <= age3 + 4'd1;
  end
  assign rdata0 = (age0 == 4'(RD_LAT)) ? rval0 : 32'hBAD0_0BAD;
  assign rdata3 = (age3 == 4'(RD_LAT)) ? rval3 : 32'hBAD0_0BAD;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor for instance 0
  always @(negedge up_clk) begin
    logic [66:0] got, exp;
    if (wr0 || rd0 || err0) begin
      got = {err0, rd0, wr0, (wr0 | rd0) ? addr0 : 32'h0, wr0 ? wdata0 : 32'h0};
      checks++;
      if (bus_exp0.size() == 0) begin
        errors++;
        $display("FAIL bus0: unexpected event %h", got);
      end else begin
        exp = bus_exp0.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL bus0: got %h expected %h", got, exp);
        end
      end
    end
    while (miso_got0.size() > 0 && miso_exp0.size() > 0) begin
      logic [7:0] g, e;
      g = miso_got0.pop_front();
      e = miso_exp0.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL miso0: got %h expected %h", g, e);
      end
    end
  end

  // Monitor for instance 3
  always @(negedge up_clk) begin
    logic [66:0] got, exp;
    if (wr3 || rd3 || err3) begin
      got = {err3, rd3, wr3, (wr3 | rd3) ? addr3 : 32'h0, wr3 ? wdata3 : 32'h0};
      checks++;
      if (bus_exp3.size() == 0) begin
        errors++;
        $display("FAIL bus3: unexpected event %h", got);
      end else begin
        exp = bus_exp3.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL bus3: got %h expected %h", got, exp);
        end
      end
    end
    while (miso_got3.size() > 0 && miso_exp3.size() > 0) begin
      logic [7:0] g, e;
      g = miso_got3.pop_front();
      e = miso_exp3.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL miso3: got %h expected %h", g, e);
      end
    end
  end

  // Driver tasks
  task automatic push_bus(input int inst, input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) bus_exp0.push_back({k, a, d}); else bus_exp3.push_back({k, a, d});
  endtask

  task automatic cs_low(input int inst);
    @(negedge up_clk);
    if (inst == 0) cs0 = 1'b0; else cs3 = 1'b0;
    #(2 * HALF);
  endtask

  task automatic cs_high(input int inst);
    #(HALF);
    if (inst == 0) cs0 = 1'b1; else cs3 = 1'b1;
    #(200);
  endtask

  task automatic spi_byte(input int inst, input logic [7:0] tx, input logic [7:0] exp_miso);
    logic [7:0] rx;
    rx = 8'h0;
    if (inst == 0) miso_exp0.push_back(exp_miso); else miso_exp3.push_back(exp_miso);
    for (int i = 7; i >= 0; i--) begin
      if (inst == 0) begin
        mosi0 = tx[i]; #(HALF);
        sclk0 = 1'b1; rx = {rx[6:0], miso0}; #(HALF);
        sclk0 = 1'b0;
      end else begin
        sclk3 = 1'b0; mosi3 = tx[i]; #(HALF);
        sclk3 = 1'b1; rx = {rx[6:0], miso3}; #(HALF);
      end
    end
    if (inst == 0) miso_got0.push_back(rx); else miso_got3.push_back(rx);
  endtask

  task automatic send_word(input int inst, input logic [31:0] w);
    for (int i = 3; i >= 0; i--) spi_byte(inst, w[i*8 +: 8], 8'h00);
  endtask

  task automatic do_write(input int inst, input logic [31:0] a, input logic [31:0] d);
    push_bus(inst, K_WR, a, d);
    cs_low(inst);
    spi_byte(inst, 8'h01, 8'h00);
    send_word(inst, a);
    send_word(inst, d);
    cs_high(inst);
  endtask

  task automatic do_read(input int inst, input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) rval0 = d; else rval3 = d;
    push_bus(inst, K_RD, a, 32'h0);
`ifdef SPI_UP_BRIDGE_BURST_EN
    push_bus(inst, K_RD, a + 32'd4, 32'h0);
`endif
    cs_low(inst);
    spi_byte(inst, 8'h02, 8'h00);
    send_word(inst, a);
    spi_byte(inst, 8'h00, 8'h00);
    for (int i = 3; i >= 0; i--) spi_byte(inst, 8'h00, d[i*8 +: 8]);
    cs_high(inst);
  endtask

  task automatic do_bad_cmd(input int inst);
    push_bus(inst, K_ER, 32'h0, 32'h0);
    cs_low(inst);
    spi_byte(inst, 8'h7F, 8'h00);
    for (int i = 0; i < 8; i++) spi_byte(inst, 8'(8'h01 + i), 8'h00);
    cs_high(inst);
  endtask

  task automatic do_burst_write(input logic [31:0] a, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = 32'h1111_1111 * (i + 1);
`ifdef SPI_UP_BRIDGE_BURST_EN
      push_bus(0, K_WR, a + 32'(4 * i), w);
`else
      if (i == 0) push_bus(0, K_WR, a, w);
`endif
    end
    cs_low(0);
    spi_byte(0, 8'h01, 8'h00);
    send_word(0, a);
    for (int i = 0; i < n; i++) send_word(0, 32'h1111_1111 * (i + 1));
    cs_high(0);
  endtask

  // Main sequence
  initial begin
    repeat (3) @(negedge up_clk);
    chk("rst_addr0", 64'(addr0), 64'h0);
    chk("rst_wdata0", 64'(wdata0), 64'h0);
    chk("rst_strobes0", {61'h0, wr0, rd0, err0}, 64'h0);
    chk("rst_miso0", 64'(miso0), 64'h0);
    chk("rst_addr3", 64'(addr3), 64'h0);
    chk("rst_strobes3", {61'h0, wr3, rd3, err3}, 64'h0);
    chk("rst_miso3", 64'(miso3), 64'h0);
    up_rst = 1'b0;
    repeat (5) @(negedge up_clk);

    // Mode 0
    do_write(0, 32'h0000_1000, 32'hDEAD_BEEF);
    do_read(0, 32'h0000_0040, 32'h1234_5678);
    do_bad_cmd(0);

    // Aborted address phase followed by a fresh write
    cs_low(0);
    spi_byte(0, 8'h01, 8'h00);
    spi_byte(0, 8'h00, 8'h00);
    spi_byte(0, 8'h00, 8'h00);
    cs_high(0);
    do_write(0, 32'h0000_2000, 32'hCAFE_F00D);

    // Reset in the middle of the data phase
    cs_low(0);
    spi_byte(0, 8'h01, 8'h00);
    send_word(0, 32'h0000_3000);
    spi_byte(0, 8'hAA, 8'h00);
    spi_byte(0, 8'hBB, 8'h00);
    @(negedge up_clk);
    up_rst = 1'b1;
    repeat (2) @(negedge up_clk);
    up_rst = 1'b0;
    @(negedge up_clk);
    chk("midrst_addr0", 64'(addr0), 64'h0);
    chk("midrst_wdata0", 64'(wdata0), 64'h0);
    chk("midrst_strobes0", {61'h0, wr0, rd0, err0}, 64'h0);
    spi_byte(0, 8'hCC, 8'h00);
    spi_byte(0, 8'hDD, 8'h00);
    cs_high(0);

    // Multi-word writes and address wrap
    do_burst_write(32'h0000_0000, 3);
    do_burst_write(32'hFFFF_FFFC, 2);

    // CPOL=1, CPHA=1
    do_write(3, 32'h0000_1000, 32'hDEAD_BEEF);
    do_read(3, 32'h0000_0040, 32'h1234_5678);
    do_bad_cmd(3);

    repeat (20) @(negedge up_clk);
    chk("pending_bus0", 64'(bus_exp0.size()), 64'h0);
    chk("pending_bus3", 64'(bus_exp3.size()), 64'h0);
    chk("pending_miso0", 64'(miso_exp0.size()), 64'h0);
    chk("pending_miso3", 64'(miso_exp3.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #(400_000);
    errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_up_bridge_os.md
Name: spi_up_bridge_os

Overview:
- Parametrised successor of the USB-SPI register bridge.
- SPI slave on the pins, microprocessor-style register bus on the core side.
- Whole block runs in one clock domain (up_clk). SPI pins are synchronised and edge-detected by oversampling, so no SPI-clock-domain logic and no cross-domain pulse stretching.
- Adds configurable address/data width, all four SPI modes, a fixed-latency read return, burst auto-increment and command error flagging.

Parameters:
- ADDR_W, 32, up_addr width; multiple of 8, range 8..32.
- DATA_W, 32, up_wr_data/up_rd_data width; multiple of 8, range 8..64.
- CPOL, 0, SPI clock idle level.
- CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
- RD_LAT, 2, up_clk cycles from up_rd pulse to up_rd_data capture; range 1..8.

Ports:
- up_clk, input, 1, sole clock; must be >= 4x SPI clock frequency.
- up_rst, input, 1, reset.
- spi_cs, input, 1, chip select, active low, asynchronous to up_clk.
- spi_clk, input, 1, SPI clock, asynchronous.
- spi_mosi, input, 1, master-out data.
- spi_miso, output, 1, slave-out data.
- up_addr, output, ADDR_W, register address, held between accesses.
- up_wr, output, 1, one-cycle write strobe.
- up_rd, output, 1, one-cycle read strobe.
- up_wr_data, output, DATA_W, write data, valid with up_wr, held after.
- up_rd_data, input, DATA_W, read data, sampled RD_LAT cycles after up_rd.
- cmd_err, output, 1, one-cycle pulse on an unknown command byte.

Behaviour:
- Clocking/reset: one clock, up_clk. Reset is synchronous and active-high on up_rst.
- Reset values: up_addr=0, up_wr=0, up_rd=0, up_wr_data=0, spi_miso=0, cmd_err=0, FSM=IDLE, bit/byte counters=0.
- Synchronisers: 2-FF sync on spi_cs, spi_clk and spi_mosi, plus one history FF on spi_clk and spi_cs for edge detect.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Bits are MSB first. Bytes are assembled in an 8-bit shift register; a byte-done pulse fires on the cycle after the 8th sample edge.
- Frame format: CMD byte, then ADDR_W/8 address bytes (MSB first), then data phase.
  - CMD 0x01 = write; CMD 0x02 = read; any other value pulses cmd_err and goes to IGNORE.
- FSM states: IDLE, CMD, ADDR, WDATA, RTURN, RDATA, IGNORE.
  - IDLE -> CMD on synchronised spi_cs falling.
  - CMD -> ADDR (valid cmd) or IGNORE.
  - ADDR -> WDATA (write) or RTURN (read) after the last address byte.
  - Read: up_rd pulses 1 cycle after the last address byte-done. up_rd_data is captured RD_LAT cycles later into the TX register.
  - RTURN: master clocks one dummy byte, MISO=0. Then RDATA shifts the captured word out, MSB first.
  - Write: after the last WDATA byte-done, up_wr_data is loaded and up_wr pulses in the same cycle.
- TX timing: for CPHA=0 the first bit is driven on entry to RDATA, before the first edge. For CPHA=1 it is driven on the first leading edge. MISO changes only on shift edges.
- spi_miso = 0 whenever spi_cs is high or the state is not RDATA.
- spi_cs rising (synchronised) in any state: return to IDLE next cycle and clear counters.
  - A partial address or partial data word produces no strobe.
  - A read already issued completes its capture silently.
- Back-to-back frames: CS high must last >= 3 up_clk cycles to be detected.
- up_wr and up_rd never assert in the same cycle. Each access produces exactly one strobe.
- Synchronous reset mid-frame: immediate return to reset values; the frame in progress is abandoned until the next CS falling edge.

Optional Feature:
- Macro SPI_UP_BRIDGE_BURST_EN.
- Defined: after a word completes with CS still low, up_addr increments by DATA_W/8 (wraps modulo 2^ADDR_W). Further write words each pulse up_wr. In reads, the next up_rd issues on the cycle the current word's last bit is shifted, and the next word follows with no extra dummy byte.
- Undefined: after one word, the FSM enters IGNORE until CS rises. Extra bytes are dropped and MISO=0.

Test Plan:
- Write, mode 0, up_clk = 8x SCLK: 01 00 00 10 00 DE AD BE EF -> a single up_wr with up_addr=0x00001000 and up_wr_data=0xDEADBEEF; up_rd never asserts.
- Read, mode 0, RD_LAT=2, up_rd_data=0x12345678: 02 00 00 00 40 + 5 dummy bytes -> up_rd once with up_addr=0x40; MISO bytes 00 12 34 56 78.
- Bad command 0x7F followed by 8 bytes -> cmd_err one pulse; no up_wr/up_rd; MISO=0 throughout.
- CS raised after 2 of 4 address bytes, then a fresh write frame -> no strobe from the first frame; the second frame writes correctly.
- CPOL=1, CPHA=1 instance: repeat the write and read tests -> identical up-bus results and MISO bytes.
- BURST_EN: write 01 00000000 + 3 words -> up_wr at addr 0x0, 0x4, 0x8; wrap test from 0xFFFFFFFC goes to 0x0. Without the macro: one up_wr only.
